// File: rtl/instr_fetch_unit.sv
// Fetch front-end: issues pipelined instruction-memory requests and queues the
// returned words with their PCs for decode. Optional perf counters: FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter int              IBUS     = 32,
    parameter int              ABUS     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ABUS-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ABUS-1:0]          imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [IBUS-1:0]          imem_rdata,
    output logic                     dec_valid,
    output logic [IBUS-1:0]          dec_instr,
    output logic [ABUS-1:0]          dec_pc,
    input  logic                     dec_ready,
    input  logic                     redirect,
    input  logic [ABUS-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     proto_err
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]              perf_fetched,
    output logic [15:0]              perf_flushed
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 16;
    localparam logic [ABUS-1:0] STEP = ABUS'(PC_STEP);

    logic [ABUS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ABUS-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic            proto_err_q, proto_err_d;

    logic [IBUS-1:0] slot_instr_q [DEPTH];
    logic [ABUS-1:0] slot_pc_q    [DEPTH];

    logic            accept;
    logic            rsp_stale;
    logic            rsp_live;
    logic            rsp_orphan;
    logic            push;
    logic            pop;
    logic [CW:0]     inflight_sum;
    logic [DW-1:0]   drop_sum;

    // Live in-flight requests each hold a reserved queue slot, so the queue cannot overflow.
    assign inflight_sum = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req     = !rst && !redirect && (inflight_sum < (CW+1)'(DEPTH));
    assign imem_addr    = fetch_pc_q;
    assign accept       = imem_req && imem_gnt;

    assign rsp_stale  = imem_rvalid && (drop_cnt_q != '0);
    assign rsp_live   = imem_rvalid && (drop_cnt_q == '0) && (outstanding_q != '0);
    assign rsp_orphan = imem_rvalid && (drop_cnt_q == '0) && (outstanding_q == '0);
    assign push       = rsp_live && !redirect;

    assign dec_valid = (count_q != '0) && !redirect;
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = (count_q != '0) ? slot_instr_q[head_q] : '0;
    assign dec_pc    = (count_q != '0) ? slot_pc_q[head_q]    : '0;
    assign occupancy = count_q;
    assign proto_err = proto_err_q;

    // Every request still in flight at a redirect becomes stale; the word arriving
    // in the redirect cycle itself is already one of them.
    always_comb begin
        drop_sum = drop_cnt_q + DW'(outstanding_q);
        if (imem_rvalid && (drop_sum != '0)) begin
            drop_sum = drop_sum - DW'(1);
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        proto_err_d   = proto_err_q | rsp_orphan;

        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            resp_pc_d     = redirect_pc;
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            outstanding_d = '0;
            drop_cnt_d    = drop_sum;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + STEP;
                tail_d    = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d       = count_q + CW'(push) - CW'(pop);
            outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_live);
            if (rsp_stale) begin
                drop_cnt_d = drop_cnt_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Slot contents need no reset: they are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_instr_q[tail_q] <= imem_rdata;
            slot_pc_q[tail_q]    <= resp_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetched_q;
    logic [15:0]   perf_flushed_q;
    logic [CW-1:0] flush_inc;
    logic [16:0]   flushed_sum;

    assign flush_inc    = (redirect ? count_q : '0) + CW'(rsp_stale || (redirect && rsp_live));
    assign flushed_sum  = {1'b0, perf_flushed_q} + 17'(flush_inc);
    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push && (perf_fetched_q != 16'hFFFF)) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            perf_flushed_q <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: in-order memory model returning word=address,
// scoreboard of accepted PCs checked at every decode handshake.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic        proto_err;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    instr_fetch_unit #(
        .IBUS(32), .ABUS(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .occupancy(occupancy), .proto_err(proto_err)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    int          accepts = 0;
    logic        inject = 1'b0;
    logic        got_first = 1'b0;
    logic [31:0] first_pc = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then drive memory response 1 time unit after posedge.
    task automatic tick();
        logic [31:0] exp;
        @(negedge clk);
        if (redirect) begin
            chk("redirect_no_req", imem_req, 1'b0);
            chk("redirect_no_valid", dec_valid, 1'b0);
            sb.delete();
            got_first = 1'b0;
        end else begin
            if (imem_req && imem_gnt) begin
                memq.push_back('{addr: imem_addr, due: cyc + lat});
                sb.push_back(imem_addr);
                accepts++;
            end
            if (dec_valid && dec_ready) begin
                n_assert++;
                assert (sb.size() != 0)
                else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_pop: observed pc %0h expected no entry", dec_pc);
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("dec_pc", dec_pc, exp);
                    chk("dec_instr", dec_instr, exp);
                end
                if (!got_first) begin
                    first_pc  = dec_pc;
                    got_first = 1'b1;
                end
                pops++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memq[0].addr;
            void'(memq.pop_front());
        end else if (inject) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            inject      = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while ((memq.size() != 0 || sb.size() != 0 || dec_valid) && i < 100) begin
            tick();
            i++;
        end
        chk(tag, 64'(sb.size() + memq.size()), 64'd0);
        chk({tag, "_occ"}, occupancy, 3'd0);
    endtask

    // Reset is asserted between edges and checked before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        dec_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        inject = 1'b0;
        memq.delete();
        sb.delete();
        #2;
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_occupancy", occupancy, 3'd0);
        chk("rst_proto_err", proto_err, 1'b0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 16'h0);
        chk("rst_perf_flushed", perf_flushed, 16'h0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);
        pops = 0;
        accepts = 0;
        got_first = 1'b0;
    endtask

    initial begin
        rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(posedge clk);
        #1;

        // Streaming: 1-cycle memory, full throughput after a 2-cycle fill.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b1;
        repeat (20) tick();
        chk("stream_pops", 64'(pops), 64'd18);
        chk("stream_occ", occupancy, 3'd1);
        imem_gnt = 1'b0;
        drain("stream_drain");

        // Backpressure: queue fills to DEPTH, requests stop, then drains in order.
        do_reset();
        lat = 1; imem_gnt = 1'b1; dec_ready = 1'b0;
        repeat (10) tick();
        chk("full_accepts", 64'(accepts), 64'd4);
        chk("full_occ", occupancy, 3'd4);
        chk("full_req", imem_req, 1'b0);
        chk("full_head_pc", dec_pc, 32'h0);
        imem_gnt = 1'b0; dec_ready = 1'b1;
        drain("full_drain");
        chk("full_pops", 64'(pops), 64'd4);

        // Redirect with three stale requests in flight on a slow memory.
        do_reset();
        lat = 4; imem_gnt = 1'b1; dec_ready = 1'b1;
        repeat (3) tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_addr", imem_addr, 32'h100);
        repeat (12) tick();
        imem_gnt = 1'b0;
        drain("redir_drain");
        chk("redir_first_pc", first_pc, 32'h100);
`ifdef FETCH_PERF_EN
        chk("redir_perf_flushed", perf_flushed, 16'd3);
        chk("redir_perf_fetched", perf_fetched, 16'(pops));
`endif

        // Redirect coinciding with a response while two requests are outstanding.
        do_reset();
        lat = 2; imem_gnt = 1'b1; dec_ready = 1'b1;
        repeat (2) tick();
        imem_gnt = 1'b0;
        chk("coinc_rvalid", imem_rvalid, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0; imem_gnt = 1'b1;
        repeat (10) tick();
        imem_gnt = 1'b0;
        drain("coinc_drain");
        chk("coinc_first_pc", first_pc, 32'h100);
`ifdef FETCH_PERF_EN
        chk("coinc_perf_flushed", perf_flushed, 16'd2);
`endif

        // PC wrap at the top of the address space.
        do_reset();
        lat = 1; imem_gnt = 1'b0; dec_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        chk("wrap_addr1", imem_addr, 32'h0);
        tick();
        chk("wrap_addr2", imem_addr, 32'h4);
        imem_gnt = 1'b0;
        drain("wrap_drain");
        chk("wrap_pops", 64'(pops), 64'd2);
        chk("wrap_proto", proto_err, 1'b0);

        // Orphan response: sticky protocol error, queue untouched, cleared by reset.
        inject = 1'b1;
        tick();
        tick();
        chk("orphan_proto", proto_err, 1'b1);
        chk("orphan_occ", occupancy, 3'd0);
        chk("orphan_valid", dec_valid, 1'b0);
        repeat (3) tick();
        chk("orphan_sticky", proto_err, 1'b1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
